// File: rtl/sram22_rw_model.sv
// Behavioural 1RW SRAM model for the sram22 family: valid/ready request port,
// per-lane write mask, 1- or 2-cycle read latency and a post-reset zero-fill.
module sram22_rw_model #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned WMASK_WIDTH  = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   rvalid,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   init_busy
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW        = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FillLast = ADDR_WIDTH'(RAM_DEPTH - 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram22_rw_model: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("sram22_rw_model: WMASK_WIDTH must divide DATA_WIDTH");
    end

    typedef enum logic {StInit, StReady} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   fill_q;
    logic                    req_ready_q;
    logic                    init_busy_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    stage_valid_q;
    logic [DATA_WIDTH-1:0]   stage_data_q;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    fill_we;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        fill_we = (state_q == StInit);
        wr_acc  = req_valid && req_ready_q && we;
        rd_acc  = req_valid && req_ready_q && !we;
        rd_word = mem[addr];
    end

    // Array has no reset; INIT zero-fills it so reads are deterministic.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_q] <= '0;
        end else if (wr_acc) begin
            for (int k = 0; k < int'(WMASK_WIDTH); k++) begin
                if (wmask[k]) begin
                    mem[addr][k*LW +: LW] <= din[k*LW +: LW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= StInit;
            fill_q        <= '0;
            req_ready_q   <= 1'b0;
            init_busy_q   <= 1'b1;
            rvalid_q      <= 1'b0;
            dout_q        <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    fill_q <= fill_q + 1'b1;
                    if (fill_q == FillLast) begin
                        state_q     <= StReady;
                        req_ready_q <= 1'b1;
                        init_busy_q <= 1'b0;
                    end
                end
                StReady: begin
                end
                default: state_q <= StInit;
            endcase

            if (READ_LATENCY == 1) begin
                rvalid_q <= rd_acc;
                if (rd_acc) dout_q <= rd_word;
            end else begin
                // Word is captured at accept, so later writes cannot disturb it.
                stage_valid_q <= rd_acc;
                if (rd_acc) stage_data_q <= rd_word;
                rvalid_q <= stage_valid_q;
                if (stage_valid_q) dout_q <= stage_data_q;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign init_busy = init_busy_q;
    assign rvalid    = rvalid_q;
    assign dout      = dout_q;

    a_req_known: assert property (@(posedge clk) disable iff (!rstb)
        (req_valid && req_ready_q) |-> !$isunknown({we, addr, wmask}))
        else $error("sram22_rw_model: X on we/addr/wmask with an accepted request");

endmodule

// File: tb/tb_sram22_rw_model.sv
// Scoreboard bench driving a latency-1 and a latency-2 instance with shared stimulus.
module tb_sram22_rw_model;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       req_valid = 1'b0;
    logic       we = 1'b0;
    logic [1:0] wmask = 2'b00;
    logic [3:0] addr = 4'h0;
    logic [7:0] din = 8'h00;

    logic       rdy1, rv1, busy1;
    logic [7:0] dout1;
    logic       rdy2, rv2, busy2;
    logic [7:0] dout2;

    sram22_rw_model #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WMASK_WIDTH(2), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(rdy1), .we(we),
        .wmask(wmask), .addr(addr), .din(din), .rvalid(rv1), .dout(dout1), .init_busy(busy1)
    );

    sram22_rw_model #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WMASK_WIDTH(2), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(rdy2), .we(we),
        .wmask(wmask), .addr(addr), .din(din), .rvalid(rv2), .dout(dout2), .init_busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Issue one request; a read's expected data and retire cycle go on both queues.
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic [1:0] m, input logic [7:0] expd, input bit push);
        @(negedge clk);
        req_valid = 1'b1;
        we        = w;
        addr      = a;
        din       = d;
        wmask     = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!w && push) begin
            q1.push_back('{expd, cyc});
            q2.push_back('{expd, cyc + 1});
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        @(negedge clk);
        rstb = 1'b1;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (rdy1 !== 1'b1 && n < 100);
        check(name, n, 16);
        check({name, "_busy1"}, busy1, 0);
        check({name, "_busy2"}, busy2, 0);
        check({name, "_rdy2"}, rdy2, 1);
    endtask

    // Monitors: every rvalid pops one expectation and checks data and retire cycle.
    always @(negedge clk) begin
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat1_unexpected_rvalid: got rvalid with dout %0h, required none", dout1);
            end else begin
                e1 = q1.pop_front();
                check("lat1_dout", dout1, e1.data);
                check("lat1_cycle", cyc, e1.cyc);
            end
        end
        if (rv2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lat2_unexpected_rvalid: got rvalid with dout %0h, required none", dout2);
            end else begin
                e2 = q2.pop_front();
                check("lat2_dout", dout2, e2.data);
                check("lat2_cycle", cyc, e2.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready1", rdy1, 0);
        check("rst_busy1", busy1, 1);
        check("rst_rvalid1", rv1, 0);
        check("rst_dout1", dout1, 0);
        check("rst_ready2", rdy2, 0);
        check("rst_busy2", busy2, 1);
        check("rst_rvalid2", rv2, 0);
        check("rst_dout2", dout2, 0);
        wait_init("init_cycles");

        for (int i = 0; i < 16; i++) issue(1'b0, 4'(i), 8'h00, 2'b00, 8'h00, 1'b1);
        repeat (3) @(negedge clk);

        issue(1'b1, 4'd5, 8'hA5, 2'b11, 8'h00, 1'b0);
        issue(1'b1, 4'd5, 8'h3C, 2'b01, 8'h00, 1'b0);
        issue(1'b0, 4'd5, 8'h00, 2'b00, 8'hAC, 1'b1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) issue(1'b1, 4'(i), 8'h10 + 8'(i), 2'b11, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) issue(1'b0, 4'(i), 8'h00, 2'b00, 8'h10 + 8'(i), 1'b1);
        repeat (3) @(negedge clk);

        issue(1'b0, 4'd2, 8'h00, 2'b00, 8'h12, 1'b1);
        issue(1'b1, 4'd2, 8'hFF, 2'b11, 8'h00, 1'b0);
        check("wr_cycle_dout1_held", dout1, 8'h12);
        check("wr_cycle_rvalid1_low", rv1, 0);
        issue(1'b0, 4'd2, 8'h00, 2'b00, 8'hFF, 1'b1);
        check("wr_cycle_dout2_held", dout2, 8'h12);
        repeat (4) @(negedge clk);

        // Read accepted, then reset lands in the next cycle: the read must vanish.
        issue(1'b0, 4'd1, 8'h00, 2'b00, 8'h00, 1'b0);
        rstb = 1'b0;
        #1;
        check("midrd_dout1", dout1, 0);
        check("midrd_dout2", dout2, 0);
        check("midrd_rvalid1", rv1, 0);
        check("midrd_rvalid2", rv2, 0);
        check("midrd_busy2", busy2, 1);
        repeat (2) @(negedge clk);
        wait_init("reinit_cycles");
        issue(1'b0, 4'd1, 8'h00, 2'b00, 8'h00, 1'b1);
        issue(1'b0, 4'd3, 8'h00, 2'b00, 8'h00, 1'b1);
        repeat (4) @(negedge clk);

        @(negedge clk);
        rstb      = 1'b0;
        req_valid = 1'b1;
        we        = 1'b1;
        addr      = 4'd7;
        din       = 8'h55;
        wmask     = 2'b11;
        repeat (2) @(negedge clk);
        wait_init("busy_init_cycles");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        issue(1'b0, 4'd7, 8'h00, 2'b00, 8'h55, 1'b1);
        issue(1'b0, 4'd6, 8'h00, 2'b00, 8'h00, 1'b1);
        repeat (5) @(negedge clk);

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram22_rw_model.md
Name: sram22_rw_model

Overview:
- Parametrised single-port 1RW SRAM behavioural model for the sram22 macro family.
- Generalised in data width, depth and mask granularity; selectable read latency of 1 or 2 cycles.
- Adds a valid/ready request interface, a read-valid output, and a post-reset zero-fill engine, so controller RTL simulates against a deterministic array.
- Sits between SRAM controller logic and the hard macro in RTL simulation.

Parameters:
- DATA_WIDTH, 8: bits per word.
- ADDR_WIDTH, 4: address bits.
- WMASK_WIDTH, 2: write-mask lanes. Must divide DATA_WIDTH; lane width LW = DATA_WIDTH/WMASK_WIDTH.
- READ_LATENCY, 1: cycles from accepted read to rvalid. Legal values are 1 and 2; any other value is an elaboration error.
- RAM_DEPTH, 1<<ADDR_WIDTH: words. Derived; do not override.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rstb, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: model can accept a request.
- we, input, 1: 1 = write, 0 = read. Sampled with the request.
- wmask, input, WMASK_WIDTH: per-lane write enable. Bit k covers din[k*LW +: LW].
- addr, input, ADDR_WIDTH: word address.
- din, input, DATA_WIDTH: write data.
- rvalid, output, 1: one-cycle pulse; dout carries read data this cycle.
- dout, output, DATA_WIDTH: read data.
- init_busy, output, 1: zero-fill in progress.

Behaviour:
- Reset is asynchronous and active-low: rstb low immediately forces:
  - FSM to INIT and fill counter to 0
  - req_ready=0, rvalid=0, dout=0, init_busy=1
  - all pipeline valid bits cleared
- The memory array is not reset asynchronously.
- FSM states are INIT and READY.
- INIT, entered on reset release:
  - Each cycle writes zero to mem[fill_cnt], then increments fill_cnt.
  - After the write to RAM_DEPTH-1, the next state is READY.
  - Exactly RAM_DEPTH cycles in INIT after the first posedge with rstb high.
  - init_busy=1 and req_ready=0 throughout INIT; req_valid is ignored.
- READY:
  - req_ready=1 and init_busy=0.
  - Accept occurs when req_valid & req_ready. Back-to-back accepts are allowed every cycle.
- Write accept:
  - Lanes with wmask[k]=1 are updated at the accepting edge; other lanes are unchanged.
  - wmask=0 is a legal no-op.
  - No rvalid is produced; dout holds its previous value (never X).
- Read accept with READ_LATENCY=1:
  - At the accepting edge, dout <= mem[addr] and rvalid <= 1.
  - rvalid is high for exactly the following cycle.
- Read accept with READ_LATENCY=2:
  - The array word is captured into a stage register at the accepting edge.
  - dout and rvalid are driven one edge later.
- rvalid falls the cycle after each pulse unless another read retires. Consecutive reads give consecutive rvalid cycles.
- dout holds the last read data until the next read retires.
- Read after write: a read to an address written in an earlier accepted cycle returns the new data. No same-cycle conflict exists, since the port is single.
- Writes accepted while a read is in the 2-stage pipe do not alter that read's captured data.
- Reset mid-operation:
  - In-flight reads are dropped; no rvalid is issued for them.
  - INIT restarts from address 0, including when reset lands mid-INIT.
- Address is always in range; no wrap logic is needed beyond the natural ADDR_WIDTH truncation.
- Simulation-only assertions:
  - req_valid with X on we, addr or wmask while req_ready=1
  - illegal READ_LATENCY

Test Plan:
- Reset/init: drop rstb for 3 cycles, release.
  - init_busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1.
  - Read of every address 0..15 returns 8'h00 with rvalid one cycle after each accept.
- Masked write: write addr 5 din 8'hA5 wmask 2'b11; then write addr 5 din 8'h3C wmask 2'b01; read addr 5.
  - dout=8'hAC with rvalid high for exactly one cycle, 1 cycle after accept.
- Back-to-back reads: fill addr 0..3 with 8'h10..8'h13, then issue 4 consecutive reads.
  - READ_LATENCY=1: rvalid high for 4 consecutive cycles with dout 10,11,12,13.
  - READ_LATENCY=2: same sequence, one cycle later.
- Write between reads: read addr 2, write addr 2 8'hFF next cycle, read addr 2.
  - First rvalid returns the old value 8'h12 (both latencies); second returns 8'hFF.
  - dout is unchanged during the write cycle.
- Reset mid-read: READ_LATENCY=2, accept a read of addr 1, assert rstb low on the following cycle.
  - No rvalid for that read; dout=0 immediately.
  - INIT reruns for 16 cycles; addr 1 then reads 8'h00.
- Requests during INIT: hold req_valid=1, we=1, addr 7, din 8'h55 throughout INIT.
  - No write takes effect before READY; the first accept is in the first READY cycle.
  - A subsequent read of addr 7 returns 8'h55.
